bin_to_bcd_digits: RTL and testbench

Sequential binary-to-BCD converter that sits directly upstream of the per-digit seven-segment decoders. It converts an unsigned binary value into NUM_DIGITS packed BCD digits using the shift-and-add-3 (double-dabble) algorithm, one shift per clock. A digit code of 4'b1111 marks a blanked digit; the downstream decoder renders that code as all segments off. The packed output is registered and holds its value between conversions, so the display never shows intermediate values.

---
 rtl/bin_to_bcd_digits.sv | 132 +++++++++++++
 tb/tb_bin_to_bcd_digits.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_digits.sv
// rtl/bin_to_bcd_digits.sv - sequential double-dabble binary to packed BCD converter with leading-zero blanking
module bin_to_bcd_digits #(
    parameter int BIN_WIDTH  = 20,
    parameter int NUM_DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_WIDTH-1:0]    binIn,
    input  logic                    blankEn,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [4*NUM_DIGITS-1:0] digitsOut
);

    localparam int DW    = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // Largest value that fits in NUM_DIGITS decimal digits
    localparam logic [63:0]   MAX_VAL      = pow10(NUM_DIGITS) - 64'd1;
    // Reset display shows a single "0" with the upper digits blanked
    localparam logic [DW-1:0] RESET_DIGITS = {{(NUM_DIGITS - 1){4'hF}}, 4'h0};
    localparam logic [DW-1:0] ALL_NINES    = {NUM_DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t               state;
    logic [BIN_WIDTH-1:0] shift_reg;
    logic [DW-1:0]        scratch;
    logic [DW-1:0]        adj;
    logic [DW-1:0]        blanked;
    logic [CNT_W-1:0]     shift_cnt;
    logic                 blank_q;
    logic                 ovf_q;
    logic                 seen_nz;
    logic [63:0]          bin_ext;

    assign bin_ext = 64'(binIn);

    // Add-3 correction, independently per 4-bit digit (no inter-digit carry)
    always_comb begin
        adj = scratch;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (scratch[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
            end
        end
    end

    // Blank every zero digit above the most significant nonzero one; digit 0 always shown
    always_comb begin
        blanked = scratch;
        seen_nz = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (scratch[4*k +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end else if (!seen_nz) begin
                blanked[4*k +: 4] = 4'hF;
            end
        end
    end

    // Control FSM with registered outputs: capture, BIN_WIDTH shifts, then publish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            scratch   <= '0;
            shift_cnt <= '0;
            blank_q   <= 1'b0;
            ovf_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            digitsOut <= RESET_DIGITS;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= binIn;
                        blank_q   <= blankEn;
                        ovf_q     <= (bin_ext > MAX_VAL);
                        scratch   <= '0;
                        shift_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch   <= {adj[DW-2:0], shift_reg[BIN_WIDTH-1]};
                    shift_reg <= {shift_reg[BIN_WIDTH-2:0], 1'b0};
                    shift_cnt <= shift_cnt + CNT_W'(1);
                    if (shift_cnt == CNT_W'(BIN_WIDTH - 1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    if (ovf_q) begin
                        digitsOut <= ALL_NINES;
                        overflow  <= 1'b1;
                    end else begin
                        digitsOut <= blank_q ? blanked : scratch;
                        overflow  <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_digits.sv
// tb/tb_bin_to_bcd_digits.sv - scoreboard bench for bin_to_bcd_digits
module tb_bin_to_bcd_digits;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [19:0] binIn;
    logic        blankEn;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [23:0] digitsOut;

    bin_to_bcd_digits #(
        .BIN_WIDTH (20),
        .NUM_DIGITS(6)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .binIn    (binIn),
        .blankEn  (blankEn),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .digitsOut(digitsOut)
    );

    typedef struct packed {
        logic [23:0] d;
        logic        o;
        logic [31:0] c;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] cyc    = 0;
    int          busy_run = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on each done pulse, also checks latency and busy length
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, expected no pending conversion");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("digitsOut", {8'h0, digitsOut}, {8'h0, e.d});
                    check("overflow", {31'h0, overflow}, {31'h0, e.o});
                    check("latency", cyc - e.c, 32'd21);
                    check("busy_cycles", busy_run, 32'd21);
                end
            end
            if (!busy) busy_run = 0;
        end
    end

    function automatic logic [23:0] ref_digits(input int v, input logic b);
        logic [23:0] r;
        int          x;
        x = v;
        if (v > 999999) return 24'h999999;
        for (int k = 0; k < 6; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        if (b) begin
            for (int k = 5; k >= 1; k--) begin
                if (r[4*k +: 4] != 4'h0) break;
                r[4*k +: 4] = 4'hF;
            end
        end
        return r;
    endfunction

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", t);
        end
    endtask

    task automatic issue(input logic [19:0] v, input logic b, input logic [23:0] ed, input logic eo);
        exp_t e;
        wait_idle();
        binIn   = v;
        blankEn = b;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.d = ed;
        e.o = eo;
        e.c = cyc;
        sb.push_back(e);
    endtask

    typedef struct {
        int          v;
        logic        b;
        logic [23:0] d;
        logic        o;
    } vec_t;

    vec_t vecs[13] = '{
        '{12345,   1'b1, 24'hF12345, 1'b0},
        '{0,       1'b1, 24'hFFFFF0, 1'b0},
        '{0,       1'b0, 24'h000000, 1'b0},
        '{999999,  1'b1, 24'h999999, 1'b0},
        '{1000000, 1'b1, 24'h999999, 1'b1},
        '{1048575, 1'b0, 24'h999999, 1'b1},
        '{7,       1'b1, 24'hFFFFF7, 1'b0},
        '{100,     1'b1, 24'hFFF100, 1'b0},
        '{90210,   1'b0, 24'h090210, 1'b0},
        '{90210,   1'b1, 24'hF90210, 1'b0},
        '{500000,  1'b1, 24'h500000, 1'b0},
        '{1,       1'b0, 24'h000001, 1'b0},
        '{45,      1'b0, 24'h000045, 1'b0}
    };

    initial begin
        int          t;
        int          rv;
        logic [31:0] acc;
        exp_t        e;

        rst_n   = 1'b0;
        start   = 1'b0;
        binIn   = '0;
        blankEn = 1'b0;
        #12;
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_overflow", {31'h0, overflow}, 32'h0);
        check("reset_digits", {8'h0, digitsOut}, 32'hFFFFF0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i].v[19:0], vecs[i].b, vecs[i].d, vecs[i].o);
        end

        // Second start during SHIFT is ignored; binIn changes have no effect
        issue(20'd654321, 1'b0, 24'h654321, 1'b0);
        repeat (5) @(negedge clk);
        binIn = 20'd111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        binIn = 20'd999;

        // start held high: back-to-back conversions every 22 cycles
        wait_idle();
        binIn   = 20'd4321;
        blankEn = 1'b1;
        start   = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        for (int i = 0; i < 3; i++) begin
            e.d = 24'hFF4321;
            e.o = 1'b0;
            e.c = acc + 32'(22 * i);
            sb.push_back(e);
        end
        while (cyc < acc + 32'd44) @(posedge clk);
        #1;
        start = 1'b0;

        // Randomised values checked against a decimal reference model
        for (int i = 0; i < 6; i++) begin
            rv = int'($urandom_range(0, 999999));
            issue(rv[19:0], i[0], ref_digits(rv, i[0]), 1'b0);
        end

        // Reset mid-SHIFT: abandon conversion, asynchronous return to reset values
        wait_idle();
        binIn   = 20'd777777;
        blankEn = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", {31'h0, busy}, 32'h0);
        check("midreset_done", {31'h0, done}, 32'h0);
        check("midreset_overflow", {31'h0, overflow}, 32'h0);
        check("midreset_digits", {8'h0, digitsOut}, 32'hFFFFF0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
        end
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
